// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : irq_controller
//  Brief    : Edge-detecting interrupt collector with mask, fixed priority
//             (index 0 highest), per-source 12-bit vectors and a
//             memory-mapped register block. Drives the core's IRQ/IRQn and
//             waits for the IRQAck handshake, including its release.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
   parameter int          NUM_SRC   = 8,
   parameter logic [13:0] BASE_ADDR = 14'h3F00
) (
   input  logic               clk,
   input  logic               nRst,
   input  logic [NUM_SRC-1:0] irqSrc,
   input  logic [13:0]        dataAddress,
   input  logic [31:0]        dataWrData,
   input  logic               dataWrEn,
   output logic [31:0]        dataRdData,
   output logic               IRQ,
   output logic [11:0]        IRQn,
   input  logic               IRQAck
);

   // Register offsets within the block (vectors live at 16 + source index)
   localparam logic [4:0] c_OFF_PENDING = 5'd0;
   localparam logic [4:0] c_OFF_MASK    = 5'd1;
   localparam logic [4:0] c_OFF_STATUS  = 5'd2;
   localparam logic [4:0] c_OFF_SWTRIG  = 5'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t             r_state;
   logic [NUM_SRC-1:0] r_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic [11:0]        r_vec [NUM_SRC];
   logic [3:0]         r_idx;

   logic               w_hit;
   logic [4:0]         w_off;
   logic               w_wr;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_sw_set;
   logic [NUM_SRC-1:0] w_w1c;
   logic [NUM_SRC-1:0] w_ack_clr;
   logic [NUM_SRC-1:0] w_active;
   logic [3:0]         w_sel;
   logic [11:0]        w_sel_vec;
   logic [31:0]        w_rd;
   logic               w_unused;

   // Only the upper address bits select the block; the low five are the offset
   assign w_hit    = (dataAddress[13:5] == BASE_ADDR[13:5]);
   assign w_off    = dataAddress[4:0];
   assign w_wr     = dataWrEn & w_hit;

   assign w_edge   = irqSrc & ~r_prev;
   assign w_sw_set = (w_wr && (w_off == c_OFF_SWTRIG))  ? dataWrData[NUM_SRC-1:0] : '0;
   assign w_w1c    = (w_wr && (w_off == c_OFF_PENDING)) ? dataWrData[NUM_SRC-1:0] : '0;
   assign w_active = r_pending & r_mask;

   // Write-data bits above the widest field are never consumed
   assign w_unused = ^{dataWrData[31:12]};

   // Acknowledge clears exactly the source currently being serviced
   always_comb begin
      w_ack_clr = '0;
      if ((r_state == S_REQ) && IRQAck) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (r_idx == 4'(i)) begin
               w_ack_clr[i] = 1'b1;
            end
         end
      end
   end

   // Fixed priority: lowest active index wins (scan downward, last hit sticks)
   always_comb begin
      w_sel = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_sel = 4'(i);
         end
      end
   end

   // Vector of the selected source
   always_comb begin
      w_sel_vec = 12'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_sel == 4'(i)) begin
            w_sel_vec = r_vec[i];
         end
      end
   end

   // Read mux from the current address; unmapped offsets and misses read zero
   always_comb begin
      w_rd = '0;
      if (w_hit) begin
         case (w_off)
            c_OFF_PENDING: w_rd[NUM_SRC-1:0] = r_pending;
            c_OFF_MASK:    w_rd[NUM_SRC-1:0] = r_mask;
            c_OFF_STATUS:  w_rd[5:0]         = {IRQ, (r_state != S_IDLE), r_idx};
            default: begin
               for (int i = 0; i < NUM_SRC; i++) begin
                  if (w_off == 5'(16 + i)) begin
                     w_rd[11:0] = r_vec[i];
                  end
               end
            end
         endcase
      end
   end

   // Edge history and pending bits; any set beats any clear in the same cycle
   always_ff @(posedge clk) begin
      r_prev <= irqSrc;
      if (nRst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_w1c & ~w_ack_clr) | w_edge | w_sw_set;
      end
   end

   // Mask and vector registers
   always_ff @(posedge clk) begin
      if (nRst) begin
         r_mask <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_vec[i] <= 12'd0;
         end
      end else begin
         if (w_wr && (w_off == c_OFF_MASK)) begin
            r_mask <= dataWrData[NUM_SRC-1:0];
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_wr && (w_off == 5'(16 + i))) begin
               r_vec[i] <= dataWrData[11:0];
            end
         end
      end
   end

   // Request handshake: issue, hold until ack, then wait for ack to drop
   always_ff @(posedge clk) begin
      if (nRst) begin
         r_state <= S_IDLE;
         r_idx   <= 4'd0;
         IRQ     <= 1'b0;
         IRQn    <= 12'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_active) begin
                  r_idx   <= w_sel;
                  IRQn    <= w_sel_vec;
                  IRQ     <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (IRQAck) begin
                  IRQ     <= 1'b0;
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!IRQAck) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               IRQ     <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Registered read data, refreshed every cycle
   always_ff @(posedge clk) begin
      if (nRst) begin
         dataRdData <= 32'd0;
      end else begin
         dataRdData <= w_rd;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_controller
//  Brief    : Directed and random stimulus for irq_controller, checked every
//             cycle against a behavioural model of the register block and
//             the request/acknowledge protocol.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;
   localparam int          NUM_SRC = 8;
   localparam logic [13:0] BASE    = 14'h3F00;

   logic        clk = 1'b0;
   logic        nRst;
   logic [7:0]  irqSrc;
   logic [13:0] dataAddress;
   logic [31:0] dataWrData;
   logic        dataWrEn;
   logic [31:0] dataRdData;
   logic        IRQ;
   logic [11:0] IRQn;
   logic        IRQAck;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: plain integers describing what the peripheral should hold
   int m_pend = 0;
   int m_mask = 0;
   int m_vec [NUM_SRC];
   int m_prev = 0;
   int m_rd   = 0;
   int m_irq  = 0;
   int m_irqn = 0;
   int m_idx  = 0;
   int m_wait_ack = 0;   // request outstanding, waiting for ack
   int m_wait_rel = 0;   // acknowledged, waiting for ack to drop

   always #5 clk = ~clk;

   irq_controller #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .irqSrc      (irqSrc),
      .dataAddress (dataAddress),
      .dataWrData  (dataWrData),
      .dataWrEn    (dataWrEn),
      .dataRdData  (dataRdData),
      .IRQ         (IRQ),
      .IRQn        (IRQn),
      .IRQAck      (IRQAck)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock: update the model from the applied inputs, then compare
   task automatic tick();
      int hit, off, wr, edges, set, clr, act, lo;
      hit = (dataAddress[13:5] == BASE[13:5]) ? 1 : 0;
      off = int'(dataAddress[4:0]);
      wr  = (dataWrEn && hit) ? 1 : 0;
      if (nRst) begin
         m_pend = 0; m_mask = 0; m_rd = 0; m_irq = 0; m_irqn = 0; m_idx = 0;
         m_wait_ack = 0; m_wait_rel = 0;
         for (int i = 0; i < NUM_SRC; i++) m_vec[i] = 0;
      end else begin
         m_rd = 0;
         if (hit) begin
            if (off == 0) m_rd = m_pend;
            else if (off == 1) m_rd = m_mask;
            else if (off == 2) m_rd = (m_irq << 5) | ((m_wait_ack | m_wait_rel) << 4) | m_idx;
            else if (off >= 16 && off < 16 + NUM_SRC) m_rd = m_vec[off - 16];
         end
         edges = int'(irqSrc) & ~m_prev & 'hFF;
         set   = edges | ((wr && off == 3) ? int'(dataWrData[7:0]) : 0);
         clr   = (wr && off == 0) ? int'(dataWrData[7:0]) : 0;
         if (m_wait_ack && IRQAck) clr = clr | (1 << m_idx);
         act = m_pend & m_mask;
         if (m_wait_ack) begin
            if (IRQAck) begin m_irq = 0; m_wait_ack = 0; m_wait_rel = 1; end
         end else if (m_wait_rel) begin
            if (!IRQAck) m_wait_rel = 0;
         end else if (act != 0) begin
            lo = 0;
            for (int i = NUM_SRC - 1; i >= 0; i--) if (((act >> i) & 1) == 1) lo = i;
            m_idx = lo; m_irqn = m_vec[lo]; m_irq = 1; m_wait_ack = 1;
         end
         if (wr && off == 1) m_mask = int'(dataWrData[7:0]);
         if (wr && off >= 16 && off < 16 + NUM_SRC) m_vec[off - 16] = int'(dataWrData[11:0]);
         m_pend = (m_pend & ~clr) | set;
      end
      m_prev = int'(irqSrc);
      @(posedge clk);
      #1;
      chk("IRQ", {31'd0, IRQ}, m_irq);
      chk("IRQn", {20'd0, IRQn}, m_irqn);
      chk("dataRdData", dataRdData, m_rd);
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      dataAddress = BASE + 14'(off);
      dataWrData  = d;
      dataWrEn    = 1'b1;
      tick();
      dataWrEn    = 1'b0;
   endtask

   // Present an address and take the read returned one cycle later
   task automatic rd(input int off, input string tag, input logic [31:0] exp);
      dataAddress = BASE + 14'(off);
      dataWrEn    = 1'b0;
      tick();
      chk(tag, dataRdData, exp);
   endtask

   initial begin
      nRst = 1'b1; irqSrc = 8'h00; dataAddress = BASE; dataWrData = 32'd0;
      dataWrEn = 1'b0; IRQAck = 1'b0;
      tick(); tick();
      nRst = 1'b0;
      chk("reset_IRQ", {31'd0, IRQ}, 32'd0);
      rd(0, "reset_PENDING", 32'd0);
      rd(1, "reset_MASK", 32'd0);

      // Single source, vector, ack and release
      wr(1, 32'h01); wr(16, 32'h123);
      irqSrc = 8'h01; dataAddress = BASE; tick();
      irqSrc = 8'h00; tick();
      chk("s1_PENDING", dataRdData, 32'h1);
      chk("s1_IRQ", {31'd0, IRQ}, 32'd1);
      chk("s1_IRQn", {20'd0, IRQn}, 32'h123);
      IRQAck = 1'b1; tick();
      chk("s1_IRQ_ack", {31'd0, IRQ}, 32'd0);
      rd(0, "s1_PENDING_clr", 32'd0);
      IRQAck = 1'b0; tick();
      rd(2, "s1_STATUS", 32'h0);

      // Two simultaneous sources: lower index first, then the other back to back
      wr(1, 32'hFF); wr(18, 32'h040); wr(21, 32'h050);
      irqSrc = 8'h24; tick();
      irqSrc = 8'h00; tick();
      chk("s2_first", {20'd0, IRQn}, 32'h040);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();
      tick();
      chk("s2_second_IRQ", {31'd0, IRQ}, 32'd1);
      chk("s2_second", {20'd0, IRQn}, 32'h050);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();
      rd(0, "s2_PENDING", 32'd0);

      // Masked source pends but stays quiet until unmasked
      wr(1, 32'h00);
      irqSrc = 8'h08; tick();
      irqSrc = 8'h00;
      rd(0, "s3_PENDING", 32'h08);
      chk("s3_IRQ_masked", {31'd0, IRQ}, 32'd0);
      wr(1, 32'h08);
      tick();
      chk("s3_IRQ_unmasked", {31'd0, IRQ}, 32'd1);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();

      // Request holds through clear/mask; set beats same-cycle W1C
      wr(1, 32'h01);
      irqSrc = 8'h01; tick();
      irqSrc = 8'h00; tick();
      wr(0, 32'h01); wr(1, 32'h00); tick();
      chk("s4_IRQ_held", {31'd0, IRQ}, 32'd1);
      irqSrc = 8'h02; wr(0, 32'h02);
      irqSrc = 8'h00;
      rd(0, "s4_set_wins", 32'h02);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();
      wr(0, 32'hFF);

      // Ack held high blocks a new request until it drops
      wr(1, 32'hFF); wr(20, 32'h0A4);
      irqSrc = 8'h01; tick();
      irqSrc = 8'h00; tick();
      IRQAck = 1'b1; irqSrc = 8'h10; tick();
      irqSrc = 8'h00; tick(); tick(); tick();
      chk("s5_IRQ_blocked", {31'd0, IRQ}, 32'd0);
      IRQAck = 1'b0; tick();
      chk("s5_IRQ_release", {31'd0, IRQ}, 32'd0);
      tick();
      chk("s5_IRQ_again", {31'd0, IRQ}, 32'd1);
      chk("s5_IRQn", {20'd0, IRQn}, 32'h0A4);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();

      // Software trigger, reset during a request, line held high across reset
      wr(1, 32'h80); wr(3, 32'h80);
      tick();
      chk("s6_sw_IRQ", {31'd0, IRQ}, 32'd1);
      rd(3, "s6_SWTRIG_rd", 32'd0);
      nRst = 1'b1; tick();
      chk("s6_rst_IRQ", {31'd0, IRQ}, 32'd0);
      nRst = 1'b0;
      rd(0, "s6_rst_PENDING", 32'd0);
      rd(1, "s6_rst_MASK", 32'd0);
      irqSrc = 8'hFF; nRst = 1'b1; tick();
      nRst = 1'b0; tick(); tick();
      rd(0, "s6_held_PENDING", 32'd0);
      irqSrc = 8'h00;

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         nRst = ($urandom_range(0, 299) == 0);
         irqSrc = irqSrc ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 9) == 0) dataAddress = 14'($urandom);
         else dataAddress = BASE + 14'($urandom_range(0, 31));
         dataWrEn   = ($urandom_range(0, 3) == 0);
         dataWrData = $urandom;
         if (IRQ) begin
            if ($urandom_range(0, 2) == 0) IRQAck = 1'b1;
         end else if ($urandom_range(0, 1) == 0) begin
            IRQAck = 1'b0;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
